// File: rtl/booth_div_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
// The master drives the operands and start; the slave returns results and flags.
interface booth_div_if #(parameter int N = 4);
   logic [N-1:0] x;
   logic [N-1:0] y;
   logic         start;
   logic [N-1:0] q;
   logic [N-1:0] r;
   logic         done;
   logic         busy;
   logic         div_zero;
   logic         ovf;

   modport master (output x, y, start, input q, r, done, busy, div_zero, ovf);
   modport slave  (input x, y, start, output q, r, done, busy, div_zero, ovf);
endinterface

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per clock, then a sign-fix step producing a truncating quotient and remainder.
module booth_div #(parameter int N = 4) (
   input  logic      clk,
   input  logic      reset,
   booth_div_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   localparam int CW = $clog2(N) + 1;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [N-1:0]  rem, rem_nxt;
   logic [N-1:0]  dq, dq_nxt;
   logic [N-1:0]  ymag, ymag_nxt;
   logic          sq, sq_nxt, sr, sr_nxt;
   logic          zpend, zpend_nxt, opend, opend_nxt;
   logic [N-1:0]  q_r, q_nxt, r_r, r_nxt;
   logic          done_r, done_nxt, busy_r, busy_nxt;
   logic          dz_r, dz_nxt, ovf_r, ovf_nxt;
   logic [N:0]    rem_sh, diff;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rem_nxt   = rem;
      dq_nxt    = dq;
      ymag_nxt  = ymag;
      sq_nxt    = sq;
      sr_nxt    = sr;
      zpend_nxt = zpend;
      opend_nxt = opend;
      q_nxt     = q_r;
      r_nxt     = r_r;
      done_nxt  = done_r;
      busy_nxt  = busy_r;
      dz_nxt    = dz_r;
      ovf_nxt   = ovf_r;
      // dq holds the dividend magnitude and shifts quotient bits in from the LSB
      rem_sh    = {rem, dq[N-1]};
      diff      = rem_sh - {1'b0, ymag};

      case (state)
         IDLE: begin
            if (bus.start) begin
               dq_nxt    = bus.x[N-1] ? -bus.x : bus.x;
               ymag_nxt  = bus.y[N-1] ? -bus.y : bus.y;
               sq_nxt    = bus.x[N-1] ^ bus.y[N-1];
               sr_nxt    = bus.x[N-1];
               zpend_nxt = (bus.y == '0);
               opend_nxt = (bus.x == {1'b1, {(N-1){1'b0}}}) && (bus.y == '1);
               cnt_nxt   = '0;
               rem_nxt   = '0;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
               dz_nxt    = 1'b0;
               ovf_nxt   = 1'b0;
               // divide-by-zero skips CALC; FIX publishes its result one edge later
               state_nxt = (bus.y == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            rem_nxt = diff[N] ? rem_sh[N-1:0] : diff[N-1:0];
            dq_nxt  = {dq[N-2:0], ~diff[N]};
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(N-1)) state_nxt = FIX;
         end
         FIX: begin
            if (zpend) begin
               q_nxt  = '1;
               r_nxt  = sr ? -dq : dq;
               dz_nxt = 1'b1;
            end else begin
               q_nxt   = sq ? -dq : dq;
               r_nxt   = sr ? -rem : rem;
               ovf_nxt = opend;
            end
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            if (!bus.start) begin
               done_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         rem    <= '0;
         dq     <= '0;
         ymag   <= '0;
         sq     <= 1'b0;
         sr     <= 1'b0;
         zpend  <= 1'b0;
         opend  <= 1'b0;
         q_r    <= '0;
         r_r    <= '0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
         dz_r   <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         rem    <= rem_nxt;
         dq     <= dq_nxt;
         ymag   <= ymag_nxt;
         sq     <= sq_nxt;
         sr     <= sr_nxt;
         zpend  <= zpend_nxt;
         opend  <= opend_nxt;
         q_r    <= q_nxt;
         r_r    <= r_nxt;
         done_r <= done_nxt;
         busy_r <= busy_nxt;
         dz_r   <= dz_nxt;
         ovf_r  <= ovf_nxt;
      end
   end

   assign bus.q        = q_r;
   assign bus.r        = r_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy_r;
   assign bus.div_zero = dz_r;
   assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_booth_div.sv
// Randomized self-checking bench for booth_div against an integer-division model.
module tb_booth_div;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   booth_div_if #(.N(N)) bus();
   booth_div #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         passed++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Truncating division as defined by SV integer / and %; a zero divisor yields
   // an all-ones quotient and the dividend as remainder.
   function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] eq, output logic [N-1:0] er,
                                   output logic edz, output logic eov);
      int ai, bi;
      ai = $signed(a);
      bi = $signed(b);
      if (bi == 0) begin
         eq = '1; er = a; edz = 1'b1; eov = 1'b0;
      end else begin
         eq  = N'(ai / bi);
         er  = N'(ai % bi);
         edz = 1'b0;
         eov = (ai == -(2 ** (N-1))) && (bi == -1);
      end
   endfunction

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
      logic [N-1:0] eq, er;
      logic edz, eov;
      int n;
      ref_div(a, b, eq, er, edz, eov);
      bus.x = a; bus.y = b; bus.start = 1'b1;
      tick;
      chk("busy_e0", bus.busy, 1);
      chk("done_e0", bus.done, 0);
      bus.x = N'($urandom);
      bus.y = N'($urandom);
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         tick;
         n++;
         if (bus.done !== 1'b1) chk("busy_calc", bus.busy, 1);
      end
      chk("latency", n, (b == '0) ? 1 : N + 1);
      chk("q", bus.q, eq);
      chk("r", bus.r, er);
      chk("div_zero", bus.div_zero, edz);
      chk("ovf", bus.ovf, eov);
      chk("busy_done", bus.busy, 0);
      for (int i = 0; i < hold; i++) begin
         tick;
         chk("done_hold", bus.done, 1);
         chk("busy_hold", bus.busy, 0);
         chk("q_hold", bus.q, eq);
      end
      bus.start = 1'b0;
      tick;
      chk("done_clr", bus.done, 0);
      chk("q_keep", bus.q, eq);
      chk("r_keep", bus.r, er);
      chk("dz_keep", bus.div_zero, edz);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_q"}, bus.q, 0);
      chk({tag, "_r"}, bus.r, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_dz"}, bus.div_zero, 0);
      chk({tag, "_ovf"}, bus.ovf, 0);
   endtask

   initial begin : main
      logic [N-1:0] a, b, lhs;
      int qi, ri, ai, bi;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.x = '0;
      bus.y = '0;
      tick;
      chk_zero("rst");
      reset = 1'b1;
      tick;

      do_op(4'd7, 4'd2, 0);
      do_op(4'b1001, 4'd2, 0);
      do_op(4'd7, 4'b1110, 0);
      do_op(4'b1000, 4'b1111, 0);
      do_op(4'd5, 4'd0, 0);
      do_op(4'b1011, 4'd3, 8);
      do_op(4'd7, 4'd2, 0);

      // abort mid-operation
      bus.x = 4'd7; bus.y = 4'd2; bus.start = 1'b1;
      tick;
      tick;
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk_zero("abort");
      bus.start = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      chk("idle_done", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
      do_op(4'd7, 4'd2, 0);

      repeat (200) begin
         a = N'($urandom);
         b = N'($urandom_range(1, (2 ** N) - 1));
         do_op(a, b, 0);
         qi = $signed(bus.q);
         ri = $signed(bus.r);
         ai = $signed(a);
         bi = $signed(b);
         lhs = N'(qi * bi + ri);
         chk("ident", lhs, a);
         chk("rmag", ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)), 1);
         chk("rsign", (ri == 0) || ((ri < 0) == (ai < 0)), 1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
